cpu_mem_target: RTL and testbench

- Memory responder (target) for the 8-bit CPU's external memory bus. The CPU is the initiator; this block serves instruction fetches and data loads/stores.
- Holds a 2^ADDR_W-byte instruction memory and a 2^ADDR_W-byte data memory.
- Accesses use a valid/ready request channel, a valid/ready response channel and programmable wait states.
- A side-band loader port preloads both memories before the CPU is released.

---
 rtl/cpu_mem_target_if.sv | 26 ++
 rtl/cpu_mem_target.sv | 215 +++++++++++++++++++++
 tb/tb_cpu_mem_target.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_target_if.sv
// Request/response bus between the CPU (master/initiator) and the memory target (slave).
interface cpu_mem_target_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_space;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_space, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_space, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/cpu_mem_target.sv
// Memory target for the 8-bit CPU: instruction + data memory, wait states, side-band loader.
// Optional access statistics (rd_cnt/wr_cnt) are built when MEM_TARGET_STATS_EN is defined.
module cpu_mem_target #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    cpu_mem_target_if.slave   bus,
    input  logic              ld_en,
    input  logic              ld_space,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt
);
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam int         DEPTH     = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q;
    logic [3:0]        wcnt_q;
    logic              op_we_q;
    logic              op_space_q;
    logic [ADDR_W-1:0] op_addr_q;
    logic [DATA_W-1:0] op_wdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              ld_ready_q;

    logic [DATA_W-1:0] imem_q [0:DEPTH-1];
    logic [DATA_W-1:0] dmem_q [0:DEPTH-1];

    logic              req_ready_s;
    logic              accept_s;
    logic              do_access_s;
    logic              acc_we_s;
    logic              acc_space_s;
    logic [ADDR_W-1:0] acc_addr_s;
    logic [DATA_W-1:0] acc_wdata_s;
    logic [DATA_W-1:0] acc_rdata_s;
    logic [DATA_W-1:0] rsp_rdata_d;
    logic              rsp_err_d;
    logic              imem_we_s;
    logic              dmem_we_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;

    // ld_ready_q is high exactly in IDLE; the loader wins over a pending request.
    assign req_ready_s = ld_ready_q && !ld_en;
    assign accept_s    = bus.req_valid && req_ready_s;
    assign do_access_s = (accept_s && NO_WAIT) || ((state_q == ST_WAIT) && (wcnt_q == 4'd0));

    // Zero-wait accesses use the live bus; otherwise the latched request.
    always_comb begin
        acc_we_s    = op_we_q;
        acc_space_s = op_space_q;
        acc_addr_s  = op_addr_q;
        acc_wdata_s = op_wdata_q;
        if (state_q == ST_IDLE) begin
            acc_we_s    = bus.req_we;
            acc_space_s = bus.req_space;
            acc_addr_s  = bus.req_addr;
            acc_wdata_s = bus.req_wdata;
        end else begin
            acc_we_s    = op_we_q;
        end
    end

    // Response payload produced by the access step.
    always_comb begin
        acc_rdata_s = acc_space_s ? dmem_q[acc_addr_s] : imem_q[acc_addr_s];
        if (acc_we_s) begin
            rsp_rdata_d = {DATA_W{1'b0}};
            rsp_err_d   = !acc_space_s;
        end else begin
            rsp_rdata_d = acc_rdata_s;
            rsp_err_d   = 1'b0;
        end
    end

    // Memory write port select: loader (IDLE only) or a CPU data-space write.
    always_comb begin
        imem_we_s = 1'b0;
        dmem_we_s = 1'b0;
        wr_addr_s = acc_addr_s;
        wr_data_s = acc_wdata_s;
        if (ld_en && ld_ready_q) begin
            imem_we_s = !ld_space;
            dmem_we_s = ld_space;
            wr_addr_s = ld_addr;
            wr_data_s = ld_data;
        end else if (do_access_s && acc_we_s && acc_space_s) begin
            dmem_we_s = 1'b1;
        end else begin
            dmem_we_s = 1'b0;
        end
    end

    // Memory arrays, intentionally not reset.
    always_ff @(posedge clk) begin
        if (imem_we_s) begin
            imem_q[wr_addr_s] <= wr_data_s;
        end
        if (dmem_we_s) begin
            dmem_q[wr_addr_s] <= wr_data_s;
        end
    end

    // Transaction FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= 4'd0;
            op_we_q     <= 1'b0;
            op_space_q  <= 1'b0;
            op_addr_q   <= {ADDR_W{1'b0}};
            op_wdata_q  <= {DATA_W{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {DATA_W{1'b0}};
            rsp_err_q   <= 1'b0;
            ld_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_we_q    <= bus.req_we;
                        op_space_q <= bus.req_space;
                        op_addr_q  <= bus.req_addr;
                        op_wdata_q <= bus.req_wdata;
                        ld_ready_q <= 1'b0;
                        if (NO_WAIT) begin
                            rsp_rdata_q <= rsp_rdata_d;
                            rsp_err_q   <= rsp_err_d;
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_RESP;
                        end else begin
                            wcnt_q  <= WAIT_LOAD;
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wcnt_q == 4'd0) begin
                        rsp_rdata_q <= rsp_rdata_d;
                        rsp_err_q   <= rsp_err_d;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ld_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    ld_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign ld_ready      = ld_ready_q;

`ifdef MEM_TARGET_STATS_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;
    logic        complete_s;

    assign complete_s = rsp_valid_q && bus.rsp_ready;

    // Saturating completion counters; rejected instruction writes count as writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
        end else if (complete_s) begin
            if (op_we_q) begin
                if (wr_cnt_q != 16'hFFFF) begin
                    wr_cnt_q <= wr_cnt_q + 16'd1;
                end
            end else begin
                if (rd_cnt_q != 16'hFFFF) begin
                    rd_cnt_q <= rd_cnt_q + 16'd1;
                end
            end
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`else
    assign rd_cnt = 16'd0;
    assign wr_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_cpu_mem_target.sv
// Directed self-checking bench for cpu_mem_target (WAIT_CYCLES=1).
module tb_cpu_mem_target;
    logic        clk;
    logic        rst_n;
    logic        ld_en;
    logic        ld_space;
    logic [3:0]  ld_addr;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;
    int          n_tests;
    int          n_fail;
    int          cyc;

    cpu_mem_target_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    cpu_mem_target #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ld_en    (ld_en),
        .ld_space (ld_space),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .rd_cnt   (rd_cnt),
        .wr_cnt   (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ld_write(input logic sp, input logic [3:0] a, input logic [7:0] d);
        int n;
        ld_en = 1'b1; ld_space = sp; ld_addr = a; ld_data = d;
        n = 0;
        while (!ld_ready && n < 20) begin
            tick();
            n++;
        end
        if (!ld_ready) check("ld_ready_timeout", 32'd0, 32'd1);
        tick();
        ld_en = 1'b0;
    endtask

    task automatic do_txn(input logic we, input logic sp, input logic [3:0] a, input logic [7:0] wd,
                          output logic [7:0] rd, output logic er, output int lat, output int acc);
        int n;
        bus.req_we = we; bus.req_space = sp; bus.req_addr = a; bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        rd = 8'h00; er = 1'b0; lat = 0; acc = 0;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            tick();
            n++;
        end
        if (!bus.req_ready) begin
            check("req_ready_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        tick();
        acc = cyc;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        tick();
    endtask

    logic [7:0] rd;
    logic       er;
    int         lat;
    int         a1;
    int         a2;
    int         n;

    initial begin
        n_tests = 0; n_fail = 0;
        rst_n = 1'b0;
        ld_en = 1'b0; ld_space = 1'b0; ld_addr = 4'd0; ld_data = 8'd0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_space = 1'b0;
        bus.req_addr = 4'd0; bus.req_wdata = 8'd0; bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        check("rst_ld_ready",  32'(ld_ready),      32'd1);
        check("rst_rd_cnt",    32'(rd_cnt),        32'd0);
        check("rst_wr_cnt",    32'(wr_cnt),        32'd0);
        rst_n = 1'b1;
        tick();

        ld_write(1'b0, 4'd0, 8'h15);
        ld_write(1'b1, 4'd3, 8'hA5);
        ld_write(1'b0, 4'd2, 8'h60);
        ld_write(1'b1, 4'd7, 8'h42);

        do_txn(1'b0, 1'b0, 4'd0, 8'h00, rd, er, lat, a1);
        check("rd_i0_data", 32'(rd), 32'h15);
        check("rd_i0_err",  32'(er), 32'd0);
        check("rd_i0_lat",  32'(lat), 32'd2);

        do_txn(1'b0, 1'b1, 4'd3, 8'h00, rd, er, lat, a1);
        check("rd_d3_data", 32'(rd), 32'hA5);

        do_txn(1'b1, 1'b1, 4'd4, 8'h3C, rd, er, lat, a1);
        check("wr_d4_rdata", 32'(rd), 32'h00);
        check("wr_d4_err",   32'(er), 32'd0);
        do_txn(1'b0, 1'b1, 4'd4, 8'h00, rd, er, lat, a2);
        check("rd_d4_data",   32'(rd), 32'h3C);
        check("b2b_spacing",  32'(a2 - a1), 32'd3);

        do_txn(1'b1, 1'b0, 4'd2, 8'hFF, rd, er, lat, a1);
        check("wr_i2_err",   32'(er), 32'd1);
        check("wr_i2_rdata", 32'(rd), 32'h00);
        do_txn(1'b0, 1'b0, 4'd2, 8'h00, rd, er, lat, a1);
        check("rd_i2_data", 32'(rd), 32'h60);
        check("rd_i2_err",  32'(er), 32'd0);

`ifdef MEM_TARGET_STATS_EN
        check("cnt_rd_a", 32'(rd_cnt), 32'd4);
        check("cnt_wr_a", 32'(wr_cnt), 32'd2);
`else
        check("cnt_rd_a", 32'(rd_cnt), 32'd0);
        check("cnt_wr_a", 32'(wr_cnt), 32'd0);
`endif

        // Response held while rsp_ready stays low.
        bus.req_we = 1'b0; bus.req_space = 1'b1; bus.req_addr = 4'd4;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("hold_valid",     32'(bus.rsp_valid), 32'd1);
            check("hold_rdata",     32'(bus.rsp_rdata), 32'h3C);
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
            tick();
        end
        check("hold_valid_end", 32'(bus.rsp_valid), 32'd1);
        bus.rsp_ready = 1'b1;
        tick();
        check("hold_done", 32'(bus.rsp_valid), 32'd0);

        // Loader and request together in IDLE: loader wins.
        ld_en = 1'b1; ld_space = 1'b1; ld_addr = 4'd9; ld_data = 8'h77;
        bus.req_we = 1'b0; bus.req_space = 1'b1; bus.req_addr = 4'd9;
        bus.req_valid = 1'b1;
        #1;
        check("conf_req_ready", 32'(bus.req_ready), 32'd0);
        check("conf_ld_ready",  32'(ld_ready),      32'd1);
        tick();
        ld_en = 1'b0;
        #1;
        check("conf_req_ready2", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check("conf_rd_data", 32'(bus.rsp_rdata), 32'h77);
        tick();

        // Reset during WAIT of a data write discards it.
        bus.req_we = 1'b1; bus.req_space = 1'b1; bus.req_addr = 4'd7; bus.req_wdata = 8'h99;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        check("rstw_in_wait", 32'(bus.req_ready), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("rstw_valid", 32'(bus.rsp_valid), 32'd0);
        check("rstw_idle",  32'(ld_ready),      32'd1);
        #1 rst_n = 1'b1;
        tick();
        check("rstw_valid2",    32'(bus.rsp_valid), 32'd0);
        check("rstw_req_ready", 32'(bus.req_ready), 32'd1);
        do_txn(1'b0, 1'b1, 4'd7, 8'h00, rd, er, lat, a1);
        check("rstw_d7_data", 32'(rd), 32'h42);

`ifdef MEM_TARGET_STATS_EN
        check("cnt_rd_b", 32'(rd_cnt), 32'd1);
        check("cnt_wr_b", 32'(wr_cnt), 32'd0);
`else
        check("cnt_rd_b", 32'(rd_cnt), 32'd0);
        check("cnt_wr_b", 32'(wr_cnt), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
